// File: rtl/final_link_adapter.sv
// Final link adapter: serialises arbiter words into LINK_WIDTH flits under credit flow control
// and reassembles received flits into an FWFT buffer. Optional feature macro: LINK_PARITY_EN.
module final_link_adapter #(
  parameter int unsigned CODE_DISTANCE_X = 5,
  parameter int unsigned CODE_DISTANCE_Z = 4,
  parameter int unsigned LINK_WIDTH      = 8,
  parameter int unsigned CREDIT_COUNT    = 4,
  localparam int unsigned DMax = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X
                                                                     : CODE_DISTANCE_Z,
  localparam int unsigned FW   = (2 * 3 * $clog2(DMax) + 2) + $clog2(DMax * CODE_DISTANCE_Z + 1),
  localparam int unsigned NF   = (FW + LINK_WIDTH - 1) / LINK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FW-1:0]         final_fifo_out_data,
  input  logic                  final_fifo_out_valid,
  output logic                  final_fifo_out_ready,
  output logic [FW-1:0]         final_fifo_in_data,
  output logic                  final_fifo_in_valid,
  input  logic                  final_fifo_in_ready,
  output logic [LINK_WIDTH-1:0] link_tx_data,
  output logic                  link_tx_valid,
  output logic                  link_tx_sop,
  output logic                  link_tx_parity,
  output logic                  link_tx_credit,
  input  logic [LINK_WIDTH-1:0] link_rx_data,
  input  logic                  link_rx_valid,
  input  logic                  link_rx_sop,
  input  logic                  link_rx_parity,
  input  logic                  link_rx_credit,
  output logic                  link_busy,
  output logic [2:0]            link_error
);

  localparam int unsigned PW  = NF * LINK_WIDTH;
  localparam int unsigned FCW = (NF > 1) ? $clog2(NF) : 1;
  localparam int unsigned CW  = $clog2(CREDIT_COUNT + 1);
  localparam int unsigned AW  = (CREDIT_COUNT > 1) ? $clog2(CREDIT_COUNT) : 1;

  localparam logic [FCW-1:0] LastFlit = FCW'(NF - 1);
  localparam logic [CW-1:0]  CredMax  = CW'(CREDIT_COUNT);
  localparam logic [AW-1:0]  LastAddr = AW'(CREDIT_COUNT - 1);

  localparam logic [0:0] TxIdle    = 1'b0;
  localparam logic [0:0] TxSend    = 1'b1;
  localparam logic [0:0] RxWaitSop = 1'b0;
  localparam logic [0:0] RxCollect = 1'b1;

  // TX state
  logic [0:0]     tx_state_q, tx_state_d;
  logic [FCW-1:0] tx_flit_q, tx_flit_d;
  logic [PW-1:0]  tx_word_q, tx_word_d;
  logic [CW-1:0]  tx_credits_q, tx_credits_d;
  logic           tx_last, tx_pop, cred_ovf;

  // RX state
  logic [0:0]     rx_state_q, rx_state_d;
  logic [FCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [PW-1:0]  rx_acc_q, rx_acc_d;
  logic           rx_perr_q, rx_perr_d;
  logic [FCW-1:0] rx_idx;
  logic [PW-1:0]  rx_word;
  logic           rx_accept, rx_done, rx_word_perr, rx_frame_err, rx_good, rx_ovf;
  logic           flit_perr;

  // RX buffer
  logic [FW-1:0]  buf_q [CREDIT_COUNT];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           buf_wr, buf_rd;

  logic           link_tx_credit_q, link_busy_q, busy_d;
  logic [2:0]     link_error_q, link_error_d;

  // ---------------------------------------------------------------------------------------------
  // TX: a new word may be popped while idle or on the last flit of the current word.
  assign tx_last  = (tx_state_q == TxSend) && (tx_flit_q == LastFlit);
  assign tx_pop   = !reset && final_fifo_out_valid && (tx_credits_q != '0) &&
                    ((tx_state_q == TxIdle) || tx_last);
  assign cred_ovf = link_rx_credit && !tx_pop && (tx_credits_q == CredMax);

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_flit_d    = tx_flit_q;
    tx_word_d    = tx_word_q;
    tx_credits_d = tx_credits_q;
    if (tx_pop) begin
      tx_state_d = TxSend;
      tx_flit_d  = '0;
      tx_word_d  = PW'(final_fifo_out_data);
    end else if (tx_last) begin
      tx_state_d = TxIdle;
    end else if (tx_state_q == TxSend) begin
      tx_flit_d = tx_flit_q + 1'b1;
    end
    if (tx_pop && !link_rx_credit) begin
      tx_credits_d = tx_credits_q - 1'b1;
    end else if (!tx_pop && link_rx_credit && !cred_ovf) begin
      tx_credits_d = tx_credits_q + 1'b1;
    end
  end

  assign final_fifo_out_ready = tx_pop;
  assign link_tx_valid        = !reset && (tx_state_q == TxSend);
  assign link_tx_sop          = link_tx_valid && (tx_flit_q == '0);
  assign link_tx_data         = link_tx_valid ? tx_word_q[int'(tx_flit_q)*LINK_WIDTH +: LINK_WIDTH]
                                              : '0;

`ifdef LINK_PARITY_EN
  assign link_tx_parity = ^link_tx_data;
  assign flit_perr      = link_rx_valid && ((^link_rx_data) != link_rx_parity);
`else
  logic unused_rx_parity;
  assign unused_rx_parity = link_rx_parity;
  assign link_tx_parity   = 1'b0;
  assign flit_perr        = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // RX: a sop flit always (re)starts assembly at chunk 0, even mid-word.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_acc_d     = rx_acc_q;
    rx_perr_d    = rx_perr_q;
    rx_accept    = link_rx_valid && (link_rx_sop || (rx_state_q == RxCollect));
    rx_idx       = link_rx_sop ? '0 : rx_cnt_q;
    rx_word      = link_rx_sop ? '0 : rx_acc_q;
    rx_word[int'(rx_idx)*LINK_WIDTH +: LINK_WIDTH] = link_rx_data;
    rx_word_perr = flit_perr || (!link_rx_sop && rx_perr_q);
    rx_done      = rx_accept && (rx_idx == LastFlit);
    rx_frame_err = link_rx_valid && (link_rx_sop ? (rx_state_q == RxCollect)
                                                 : (rx_state_q == RxWaitSop));
    if (rx_done) begin
      rx_state_d = RxWaitSop;
      rx_cnt_d   = '0;
      rx_perr_d  = 1'b0;
    end else if (rx_accept) begin
      rx_state_d = RxCollect;
      rx_cnt_d   = rx_idx + 1'b1;
      rx_acc_d   = rx_word;
      rx_perr_d  = rx_word_perr;
    end
  end

  if (PW > FW) begin : gen_pad_sink
    logic unused_pad;
    assign unused_pad = ^rx_word[PW-1:FW];
  end

  assign final_fifo_in_valid = !reset && (count_q != '0);
  assign final_fifo_in_data  = final_fifo_in_valid ? buf_q[rd_ptr_q] : '0;
  assign buf_rd  = final_fifo_in_ready && final_fifo_in_valid;
  // Words with a parity error are dropped without consuming a slot or returning a credit.
  assign rx_good = rx_done && !rx_word_perr;
  assign buf_wr  = rx_good && ((count_q != CredMax) || buf_rd);
  assign rx_ovf  = rx_good && !buf_wr;

  assign link_error_d = link_error_q | {rx_done && rx_word_perr, rx_frame_err || rx_ovf, cred_ovf};
  assign busy_d       = (tx_state_q == TxSend) || (rx_state_q == RxCollect) || (count_q != '0) ||
                        final_fifo_out_valid || (tx_credits_q != CredMax);

  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_q[wr_ptr_q] <= rx_word[FW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q       <= TxIdle;
      tx_flit_q        <= '0;
      tx_word_q        <= '0;
      tx_credits_q     <= CredMax;
      rx_state_q       <= RxWaitSop;
      rx_cnt_q         <= '0;
      rx_acc_q         <= '0;
      rx_perr_q        <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      link_tx_credit_q <= 1'b0;
      link_busy_q      <= 1'b0;
      link_error_q     <= '0;
    end else begin
      tx_state_q       <= tx_state_d;
      tx_flit_q        <= tx_flit_d;
      tx_word_q        <= tx_word_d;
      tx_credits_q     <= tx_credits_d;
      rx_state_q       <= rx_state_d;
      rx_cnt_q         <= rx_cnt_d;
      rx_acc_q         <= rx_acc_d;
      rx_perr_q        <= rx_perr_d;
      link_tx_credit_q <= buf_rd;
      link_busy_q      <= busy_d;
      link_error_q     <= link_error_d;
      if (buf_wr) begin
        wr_ptr_q <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (buf_rd) begin
        rd_ptr_q <= (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (buf_wr && !buf_rd) begin
        count_q <= count_q + 1'b1;
      end else if (!buf_wr && buf_rd) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign link_tx_credit = !reset && link_tx_credit_q;
  assign link_busy      = !reset && link_busy_q;
  assign link_error     = reset ? 3'b000 : link_error_q;

endmodule

// File: tb/tb_final_link_adapter.sv
// Bench for final_link_adapter: flit vector table, multi-cycle corner sequences and a
// randomized TX->RX loopback checked against a queue/credit reference model.
module tb_final_link_adapter;
  localparam int unsigned LW = 8;
  localparam int unsigned FW = 25;
  localparam int unsigned NF = 4;
  localparam int unsigned CC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] out_data, in_data;
  logic          out_valid, out_ready, in_valid, in_ready;
  logic [LW-1:0] tx_data, rx_data, d_rx_data;
  logic          tx_valid, tx_sop, tx_parity, tx_credit;
  logic          rx_valid, rx_sop, rx_parity, rx_credit;
  logic          d_rx_valid, d_rx_sop, d_rx_parity, d_rx_credit;
  logic          busy, loop_en;
  logic [2:0]    err;

  int n_tests = 0;
  int n_fail  = 0;

  assign rx_data   = loop_en ? tx_data   : d_rx_data;
  assign rx_valid  = loop_en ? tx_valid  : d_rx_valid;
  assign rx_sop    = loop_en ? tx_sop    : d_rx_sop;
  assign rx_parity = loop_en ? tx_parity : d_rx_parity;
  assign rx_credit = loop_en ? tx_credit : d_rx_credit;

  final_link_adapter dut (
    .clk                  (clk),
    .reset                (reset),
    .final_fifo_out_data  (out_data),
    .final_fifo_out_valid (out_valid),
    .final_fifo_out_ready (out_ready),
    .final_fifo_in_data   (in_data),
    .final_fifo_in_valid  (in_valid),
    .final_fifo_in_ready  (in_ready),
    .link_tx_data         (tx_data),
    .link_tx_valid        (tx_valid),
    .link_tx_sop          (tx_sop),
    .link_tx_parity       (tx_parity),
    .link_tx_credit       (tx_credit),
    .link_rx_data         (rx_data),
    .link_rx_valid        (rx_valid),
    .link_rx_sop          (rx_sop),
    .link_rx_parity       (rx_parity),
    .link_rx_credit       (rx_credit),
    .link_busy            (busy),
    .link_error           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [FW-1:0]          word;
    logic [NF-1:0][LW-1:0]  flits;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic exp_par(input logic [LW-1:0] d);
`ifdef LINK_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1; loop_en = 1'b0;
    out_valid = 1'b1; out_data = '1; in_ready = 1'b1;
    d_rx_valid = 1'b0; d_rx_sop = 1'b0; d_rx_data = '0; d_rx_parity = 1'b0; d_rx_credit = 1'b0;
    next_cycle();
    next_cycle();
    sample();
    check("reset out_ready", out_ready, 0);
    check("reset in_valid", in_valid, 0);
    check("reset in_data", in_data, 0);
    check("reset tx_valid", tx_valid, 0);
    check("reset tx_sop", tx_sop, 0);
    check("reset tx_data", tx_data, 0);
    check("reset tx_parity", tx_parity, 0);
    check("reset tx_credit", tx_credit, 0);
    check("reset busy", busy, 0);
    check("reset error", err, 0);
    check("reset credits", dut.tx_credits_q, CC);
    next_cycle();
    reset = 1'b0; out_valid = 1'b0; out_data = '0; in_ready = 1'b0;
  endtask

  // Presents w until popped; returns at the drive point of the cycle after the pop.
  task automatic push_word(input logic [FW-1:0] w, input bit with_credit);
    bit got = 1'b0;
    out_valid = 1'b1; out_data = w;
    for (int i = 0; i < 20 && !got; i++) begin
      sample();
      if (out_ready) got = 1'b1;
      else next_cycle();
    end
    check("push accepted", got, 1);
    if (got && with_credit) d_rx_credit = 1'b1;
    next_cycle();
    out_valid = 1'b0; d_rx_credit = 1'b0;
  endtask

  task automatic rx_flit(input logic [LW-1:0] d, input bit sop, input bit flip);
    d_rx_valid = 1'b1; d_rx_sop = sop; d_rx_data = d; d_rx_parity = (^d) ^ flip;
    next_cycle();
    d_rx_valid = 1'b0; d_rx_sop = 1'b0;
  endtask

  task automatic send_rx_word(input logic [FW-1:0] w, input int flip_idx);
    logic [NF*LW-1:0] pw;
    pw = {{(NF*LW-FW){1'b0}}, w};
    for (int f = 0; f < NF; f++) rx_flit(pw[f*LW +: LW], f == 0, f == flip_idx);
  endtask

  task automatic run_loopback(input int n_words, input int hold_cycles, input bit rand_mode);
    logic [FW-1:0] words[$];
    logic [FW-1:0] expq[$];
    int idx = 0, m_cred = CC, last_pop = -100, cyc = 0, delivered = 0;
    bit del_p1 = 1'b0, del_p2 = 1'b0, presenting = 1'b0, del_now, exp_ready;
    for (int i = 0; i < n_words; i++) words.push_back(FW'($urandom));
    loop_en = 1'b1;
    while ((delivered < n_words) && (cyc < 2000)) begin
      next_cycle();
      if ((idx < n_words) && (presenting || !rand_mode || ($urandom_range(0, 3) != 0))) begin
        presenting = 1'b1; out_valid = 1'b1; out_data = words[idx];
      end else begin
        out_valid = 1'b0;
      end
      in_ready = (cyc >= hold_cycles) && (!rand_mode || ($urandom_range(0, 2) != 0));
      sample();
      // A delivery returns a credit pulse one cycle later, usable by TX the cycle after that.
      m_cred += int'(del_p2);
      check($sformatf("loop c%0d credit pulse", cyc), tx_credit, del_p1);
      exp_ready = out_valid && (m_cred > 0) && (cyc >= last_pop + int'(NF));
      check($sformatf("loop c%0d ready", cyc), out_ready, exp_ready);
      if (out_ready && (idx < n_words)) begin
        expq.push_back(words[idx]);
        idx++; last_pop = cyc; m_cred--; presenting = 1'b0;
      end
      if ((hold_cycles > 0) && (cyc == hold_cycles - 1)) check("loop sent while blocked", idx, CC);
      del_now = 1'b0;
      if (in_valid && in_ready) begin
        if (expq.size() == 0) check("loop unexpected word", in_valid, 0);
        else check($sformatf("loop word %0d", delivered), in_data, expq.pop_front());
        del_now = 1'b1;
        delivered++;
      end
      del_p2 = del_p1; del_p1 = del_now;
      cyc++;
    end
    check("loop all delivered", delivered, n_words);
    next_cycle();
    out_valid = 1'b0; in_ready = 1'b0;
    repeat (5) next_cycle();
    sample();
    check("loop drained busy", busy, 0);
    check("loop drained credits", dut.tx_credits_q, CC);
    check("loop drained error", err, 0);
    next_cycle();
    loop_en = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    logic [FW-1:0] rw[5];
    int cnt;

    vecs[0] = '{word: 25'h1ABCDEF, flits: {8'h01, 8'hAB, 8'hCD, 8'hEF}};
    vecs[1] = '{word: 25'h0000000, flits: {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{word: 25'h1FFFFFF, flits: {8'h01, 8'hFF, 8'hFF, 8'hFF}};
    vecs[3] = '{word: 25'h1000000, flits: {8'h01, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{word: 25'h0AA55AA, flits: {8'h00, 8'hAA, 8'h55, 8'hAA}};

    do_reset();

    // Flit serialisation, credit decrement and restore.
    for (int v = 0; v < 5; v++) begin
      push_word(vecs[v].word, 1'b0);
      for (int f = 0; f < NF; f++) begin
        sample();
        check($sformatf("vec%0d flit%0d valid", v, f), tx_valid, 1);
        check($sformatf("vec%0d flit%0d sop", v, f), tx_sop, f == 0);
        check($sformatf("vec%0d flit%0d data", v, f), tx_data, vecs[v].flits[f]);
        check($sformatf("vec%0d flit%0d parity", v, f), tx_parity, exp_par(vecs[v].flits[f]));
        if (f == 0) check($sformatf("vec%0d credits after pop", v), dut.tx_credits_q, CC - 1);
        next_cycle();
      end
      sample();
      check($sformatf("vec%0d idle after word", v), tx_valid, 0);
      d_rx_credit = 1'b1;
      next_cycle();
      d_rx_credit = 1'b0;
      sample();
      check($sformatf("vec%0d credit restored", v), dut.tx_credits_q, CC);
      next_cycle();
    end

    // Credit overflow, then pop coinciding with a credit pulse.
    do_reset();
    d_rx_credit = 1'b1;
    next_cycle();
    d_rx_credit = 1'b0;
    sample();
    check("credit ovf count", dut.tx_credits_q, CC);
    check("credit ovf error", err, 3'b001);
    do_reset();
    push_word(25'h0000011, 1'b0);
    push_word(25'h0000022, 1'b0);
    sample();
    check("credits after two pops", dut.tx_credits_q, CC - 2);
    next_cycle();
    push_word(25'h0000033, 1'b1);
    sample();
    check("pop+credit count", dut.tx_credits_q, CC - 2);
    check("pop+credit error", err, 0);

    // Reset mid-word aborts the word.
    do_reset();
    push_word(25'h1234567, 1'b0);
    next_cycle();
    reset = 1'b1;
    sample();
    check("midword reset tx_valid", tx_valid, 0);
    next_cycle();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (tx_valid) cnt++;
      next_cycle();
    end
    check("midword reset no flits", cnt, 0);
    check("midword reset credits", dut.tx_credits_q, CC);

    // RX buffer full: fifth word dropped, first four kept in order with credits returned.
    do_reset();
    for (int i = 0; i < 5; i++) rw[i] = FW'($urandom);
    for (int i = 0; i < 4; i++) send_rx_word(rw[i], -1);
    sample();
    check("rx 4 words no error", err, 0);
    check("rx 4 words valid", in_valid, 1);
    check("rx 4 words busy", busy, 1);
    next_cycle();
    send_rx_word(rw[4], -1);
    sample();
    check("rx overflow error", err, 3'b010);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      in_ready = 1'b1;
      sample();
      check($sformatf("rx buf valid %0d", i), in_valid, 1);
      check($sformatf("rx buf data %0d", i), in_data, rw[i]);
      next_cycle();
      in_ready = 1'b0;
      sample();
      check($sformatf("rx credit pulse %0d", i), tx_credit, 1);
      next_cycle();
      sample();
      check($sformatf("rx credit pulse end %0d", i), tx_credit, 0);
    end
    check("rx buffer empty", in_valid, 0);

    // Stray non-sop flit while waiting for sop is dropped.
    do_reset();
    rx_flit(8'h5A, 1'b0, 1'b0);
    sample();
    check("stray flit error", err, 3'b010);
    check("stray flit no word", in_valid, 0);

    // sop re-asserted on the third flit restarts assembly.
    do_reset();
    rw[0] = FW'($urandom);
    rx_flit(8'h11, 1'b1, 1'b0);
    rx_flit(8'h22, 1'b0, 1'b0);
    send_rx_word(rw[0], -1);
    sample();
    check("resync error", err, 3'b010);
    check("resync valid", in_valid, 1);
    check("resync data", in_data, rw[0]);

    // Parity flip on flit 2.
    do_reset();
    rw[1] = FW'($urandom);
`ifdef LINK_PARITY_EN
    in_ready = 1'b1;
    send_rx_word(rw[1], 2);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (in_valid || tx_credit) cnt++;
      next_cycle();
    end
    check("parity bad word not delivered", cnt, 0);
    check("parity error flag", err, 3'b100);
    in_ready = 1'b0;
`else
    send_rx_word(rw[1], 2);
    sample();
    check("no parity word kept", in_valid, 1);
    check("no parity word data", in_data, rw[1]);
    check("no parity error clear", err, 0);
`endif

    // Loopback: credit-limited burst, then randomized traffic.
    do_reset();
    run_loopback(6, 40, 1'b0);
    do_reset();
    run_loopback(30, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/final_link_adapter.md
FINAL_LINK_ADAPTER -- requirements
Module: final_link_adapter

Interface
REQ-001 SHALL have parameter CODE_DISTANCE_X, default 5, the X code distance.
REQ-002 SHALL have parameter CODE_DISTANCE_Z, default 4, the Z code distance.
REQ-003 SHALL have parameter LINK_WIDTH, default 8, the flit payload width.
REQ-004 SHALL have parameter CREDIT_COUNT, default 4, the RX buffer depth in words; power of 2, at most 16.
REQ-005 SHALL derive FW = final word width = (2*3*clog2(max(X,Z)) + 2) + clog2(X... i.e. max(X,Z)*Z + 1); default 25.
REQ-006 SHALL derive NF = ceil(FW/LINK_WIDTH); default 4.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have ports final_fifo_out_data (in, FW), final_fifo_out_valid (in, 1) and final_fifo_out_ready (out, 1): the arbiter output FIFO, FWFT; ready is the pop.
REQ-010 SHALL have ports final_fifo_in_data (out, FW), final_fifo_in_valid (out, 1) and final_fifo_in_ready (in, 1): the arbiter input FIFO.
REQ-011 SHALL have ports link_tx_data (out, LINK_WIDTH), link_tx_valid (out, 1), link_tx_sop (out, 1), link_tx_parity (out, 1) and link_tx_credit (out, 1 pulse).
REQ-012 SHALL have ports link_rx_data (in, LINK_WIDTH), link_rx_valid (in, 1), link_rx_sop (in, 1), link_rx_parity (in, 1) and link_rx_credit (in, 1 pulse).
REQ-013 SHALL have ports link_busy (out, 1) and link_error (out, 3, sticky): bit 0 credit overflow, bit 1 RX overflow/framing, bit 2 parity.

Function
REQ-014 TX FSM SHALL have states IDLE and SEND, with credit counter tx_credits over the range 0..CREDIT_COUNT.
REQ-015 TX SHALL assert final_fifo_out_ready combinationally when (IDLE, or SEND on the last flit) and final_fifo_out_valid and tx_credits>0; the word is captured and tx_credits decremented.
REQ-016 TX SHALL emit NF flits on consecutive cycles starting the cycle after the pop, LSB chunk first with zero-padded top; sop on flit 0 only; back-to-back words have no gap.
REQ-017 On a link_rx_credit pulse, tx_credits SHALL increment; when it coincides with a pop, the count is unchanged.
REQ-018 A credit pulse at tx_credits==CREDIT_COUNT SHALL be ignored and SHALL set link_error[0].
REQ-019 RX FSM SHALL have states WAIT_SOP and COLLECT with a flit counter 0..NF-1.
REQ-020 In WAIT_SOP, a valid flit without sop SHALL be dropped and SHALL set link_error[1].
REQ-021 In COLLECT, a sop flit SHALL set link_error[1], discard the partial word, and restart assembly from that flit.
REQ-022 The assembled word SHALL be written to the RX circular buffer the cycle after its last flit; a write to a full buffer drops the word and sets link_error[1].
REQ-023 final_fifo_in_valid SHALL equal buffer-not-empty and final_fifo_in_data SHALL equal the head (FWFT); a simultaneous read and write on a full buffer is legal.
REQ-024 Each buffer pop SHALL produce a registered one-cycle link_tx_credit pulse on the next cycle.
REQ-025 link_busy SHALL be registered and high if TX is in SEND, RX is in COLLECT, the buffer is non-empty, final_fifo_out_valid is high, or tx_credits!=CREDIT_COUNT.

Reset
REQ-026 During reset, all outputs SHALL be 0, link_error SHALL be cleared, tx_credits SHALL be CREDIT_COUNT, both FSMs SHALL be idle, and the buffer SHALL be empty.
REQ-027 A reset mid-word SHALL abort in-flight flits with no partial emission after the reset cycle.

Configuration
REQ-028 With LINK_PARITY_EN defined, link_tx_parity SHALL be the even parity (XOR) of link_tx_data for each flit.
REQ-029 With LINK_PARITY_EN defined, RX SHALL check every flit; on any mismatch the word is dropped at completion, link_error[2] is set, and no credit is returned.
REQ-030 Without LINK_PARITY_EN, link_tx_parity SHALL be 0, link_rx_parity SHALL be ignored, and link_error[2] SHALL stay 0.

Verification
REQ-031 Defaults, push word 25'h1ABCDEF -> flits EF(sop),CD,AB,01 on cycles 1-4 after the pop; tx_credits goes 4->3.
REQ-032 Loopback of TX to RX, 6 words, no credit return beyond the loop -> 4 words sent, then ready stays low until credit pulses; all 6 words are delivered in order.
REQ-033 final_fifo_in_ready=0 with 4 words received; inject a 5th -> word dropped, link_error[1]=1, buffer still holds the first 4.
REQ-034 Credit pulse at tx_credits=4 -> count stays 4 and link_error[0]=1; pop plus credit in the same cycle at 2 -> stays 2.
REQ-035 LINK_PARITY_EN defined, flip parity on flit 2 -> no word output, no credit pulse, link_error[2]=1.
REQ-036 sop re-asserted on flit 2 -> link_error[1]=1; the following 4 flits from that sop assemble correctly.
